// File: rtl/lcd_pkg.sv
// lcd_pkg: panel geometry and receiver state encoding shared with the transmitter
package lcd_pkg;
  localparam int LCD_WIDTH = 640;
  localparam int LCD_HIGHT = 480;
  localparam int H_BLANKING = 160;
  localparam int V_BLANKING = 45;
  localparam int VGAP_MIN = 1024;
  typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE, HBLANK} state_t;
endpackage

// File: rtl/lcd_rgb_receiver.sv
// lcd_rgb_receiver: DE-mode RGB capture with pixel coordinates, frame boundaries and geometry checks
module lcd_rgb_receiver #(
  parameter int LCD_WIDTH = lcd_pkg::LCD_WIDTH,
  parameter int LCD_HIGHT = lcd_pkg::LCD_HIGHT,
  parameter int VGAP_MIN = lcd_pkg::VGAP_MIN
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        de,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err,
  output logic [18:0] lit_count
);
  import lcd_pkg::*;
  localparam logic [10:0] W = 11'(LCD_WIDTH);
  localparam logic [9:0] H = 10'(LCD_HIGHT);
  localparam logic [10:0] G = 11'(VGAP_MIN);
  state_t state, state_n;
  logic [10:0] col, col_n, low_run, low_run_n, px;
  logic [9:0] row, row_n, py;
  logic [18:0] lit_acc, lit_acc_n, lit_base;
  logic [23:0] rgb;
  logic pixel, valid, fall, gap;
  // next state, counters and pixel qualification from the current sample
  always_comb begin
    rgb = {red, green, blue};
    pixel = de && state != SYNC;
    fall = !de && state == ACTIVE;
    gap = !de && (state == SYNC || state == HBLANK) && low_run == G - 1'b1;
    px = state == ACTIVE ? col : '0;
    py = state == VBLANK ? '0 : row;
    valid = pixel && px < W && py < H;
    state_n = pixel ? ACTIVE : gap ? VBLANK : state == ACTIVE ? HBLANK : state;
    col_n = pixel ? (px == '1 ? px : px + 1'b1) : '0;
    row_n = state == VBLANK ? '0 : fall && row != '1 ? row + 1'b1 : row;
    low_run_n = de ? '0 : state == ACTIVE ? 11'd1 : low_run == G ? G : low_run + 1'b1;
    lit_base = state == VBLANK ? '0 : lit_acc;
    lit_acc_n = valid && rgb != '0 && lit_base != '1 ? lit_base + 1'b1 : lit_base;
  end
  // state/counter registers and registered outputs; frame stats latch on frame_done
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state <= SYNC;
      col <= '0;
      row <= '0;
      low_run <= '0;
      lit_acc <= '0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_rgb <= '0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
      line_err <= 1'b0;
      frame_err <= 1'b0;
      lit_count <= '0;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      low_run <= low_run_n;
      lit_acc <= lit_acc_n;
      pix_valid <= valid;
      if (pixel) begin
        pix_x <= px[9:0];
        pix_y <= py;
        pix_rgb <= rgb;
      end
      frame_start <= pixel && state == VBLANK;
      frame_done <= gap && state == HBLANK;
      line_err <= pixel && state == VBLANK ? 1'b0 : line_err | (fall && col != W);
      if (gap && state == HBLANK) begin
        frame_err <= row != H;
        lit_count <= lit_acc;
      end
    end
  end
endmodule

// File: tb/tb_lcd_rgb_receiver.sv
// tb_lcd_rgb_receiver: scoreboard bench for the RGB receiver on a reduced panel geometry
module tb_lcd_rgb_receiver;
  localparam int W = 16;
  localparam int H = 8;
  localparam int G = 32;
  localparam int HB = 8;
  localparam int VBL = 4 * (W + HB);
  logic clk = 1'b0, rst = 1'b1, de = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic pix_valid, frame_start, frame_done, line_err, frame_err;
  logic [9:0] pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic [18:0] lit_count;
  logic [44:0] pq[$];
  logic [20:0] fq[$];
  int n_chk = 0, n_fail = 0;

  lcd_rgb_receiver #(.LCD_WIDTH(W), .LCD_HIGHT(H), .VGAP_MIN(G)) dut (
    .pixel_clk(clk), .rst(rst), .de(de), .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err),
    .frame_err(frame_err), .lit_count(lit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit d, input logic [23:0] v);
    de = d;
    {red, green, blue} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n, input bit done, input bit chk, input bit lerr);
    for (int i = 1; i <= n; i++) begin
      drive(1'b0, 24'h0);
      if (chk && i == 1) check("line_err", 64'(line_err), 64'(lerr));
      check("frame_done", 64'(frame_done), 64'(done && i == G));
    end
  endtask

  task automatic send_frame(input int nl, input int sr, input int sl, input int gr, input int gl,
                            input int rr, input int rc, input int vg, input bit mode, input bit cap);
    int lit = 0;
    bit lerr = 0;
    int len;
    logic [23:0] v;
    for (int r = 0; r < nl; r++) begin
      len = r == sr ? sl : W;
      for (int c = 0; c < len; c++) begin
        v = mode ? ($urandom_range(0, 3) == 0 ? 24'h0 : 24'($urandom)) : (c % 2 == 0 ? 24'hFFFFFF : 24'h0);
        if (r == rr && c == rc) begin
          rst = 1'b1;
          drive(1'b1, v);
          rst = 1'b0;
          cap = 1'b0;
          check("rst_pix", 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'(0));
          check("rst_stat", 64'({frame_start, frame_done, line_err, frame_err, lit_count}), 64'(0));
          continue;
        end
        if (cap && c < W && r < H) begin
          pq.push_back({1'(r == 0 && c == 0), 10'(c), 10'(r), v});
          if (v != 24'h0) lit++;
        end
        drive(1'b1, v);
        if (cap && r == 0 && c == 0) check("line_err_clr", 64'(line_err), 64'(0));
      end
      lerr |= len != W;
      if (r == nl - 1) begin
        if (cap) fq.push_back({19'(lit), 1'(nl != H), lerr});
        gap(vg, cap, cap, lerr);
      end else gap(r == gr ? gl : HB, 1'b0, cap, lerr);
    end
  endtask

  // scoreboard: every reported pixel and frame_done is matched against queued expectations
  always @(negedge clk) begin
    if (pix_valid) begin
      if (pq.size() == 0) check("pix_extra", 64'(pix_valid), 64'(0));
      else check("pixel", 64'({frame_start, pix_x, pix_y, pix_rgb}), 64'(pq.pop_front()));
    end else if (frame_start) check("frame_start", 64'(frame_start), 64'(0));
    if (frame_done) begin
      if (fq.size() == 0) check("frame_extra", 64'(frame_done), 64'(0));
      else check("frame_stats", 64'({lit_count, frame_err, line_err}), 64'(fq.pop_front()));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_pix", 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'(0));
    check("reset_stat", 64'({frame_start, frame_done, line_err, frame_err, lit_count}), 64'(0));
    rst = 1'b0;
    send_frame(H, -1, 0, -1, 0, -1, -1, VBL, 1'b1, 1'b0);
    repeat (3) send_frame(H, -1, 0, -1, 0, -1, -1, VBL, 1'b0, 1'b1);
    send_frame(H, 3, W - 1, -1, 0, -1, -1, VBL, 1'b1, 1'b1);
    send_frame(H, 5, W + 10, -1, 0, -1, -1, VBL, 1'b1, 1'b1);
    send_frame(H + 1, -1, 0, -1, 0, -1, -1, VBL, 1'b1, 1'b1);
    send_frame(H - 1, -1, 0, -1, 0, -1, -1, VBL, 1'b1, 1'b1);
    send_frame(H, -1, 0, -1, 0, 3, 5, VBL, 1'b1, 1'b1);
    send_frame(H, -1, 0, -1, 0, -1, -1, VBL, 1'b1, 1'b1);
    send_frame(H, -1, 0, 2, G - 1, -1, -1, G, 1'b1, 1'b1);
    send_frame(H, -1, 0, -1, 0, -1, -1, VBL, 1'b0, 1'b1);
    check("pix_q_empty", 64'(pq.size()), 64'(0));
    check("frame_q_empty", 64'(fq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_rgb_receiver.md
# lcd_rgb_receiver

Receive-side counterpart of the LCD pixel/timing generator: samples a parallel 24-bit RGB bus qualified by DE (ENB, DE mode, no HSYNC/VSYNC) and reconstructs pixel column/row coordinates. It also detects frame boundaries from the vertical-blanking gap and checks line length and line count against the panel geometry. It sits on the loopback/capture path (FPGA banks A–D looped back, or a capture FPGA) and feeds per-pixel data plus per-frame statistics to test logic and LEDs.

## Interface
- LCD_WIDTH, 640, active pixels per line
- LCD_HIGHT, 480, active lines per frame
- VGAP_MIN, 1024, consecutive DE-low samples that mark vertical blanking; must exceed the horizontal blanking length (160)
- pixel_clk  in  1  sole clock; all inputs sampled on rising edge
- rst  in  1  reset; synchronous and active-high
- de  in  1  data enable (ENB)
- red, green, blue  in  8 each  pixel data; valid only when de=1
- pix_valid  out  1  registered; pixel in active area
- pix_x  out  10  column of the pixel on pix_rgb
- pix_y  out  10  row of the pixel on pix_rgb
- pix_rgb  out  24  {red,green,blue}
- frame_start  out  1  one-cycle pulse with the first pixel of row 0
- frame_done  out  1  one-cycle pulse when vertical blanking is detected after a frame
- line_err  out  1  sticky per frame: some line length ≠ LCD_WIDTH
- frame_err  out  1  row count at frame_done ≠ LCD_HIGHT
- lit_count  out  19  count of pixels with rgb≠0 in the last completed frame

## Operation
- States: SYNC, VBLANK, ACTIVE, HBLANK.
- Counters:
  - col (11 b): saturates at 2047.
  - row (10 b): saturates at 1023.
  - low_run (11 b): saturates at VGAP_MIN.
  - lit_acc (19 b): saturates at 2^19-1.
- SYNC (reset state):
  - de=1 clears low_run; pixels are ignored.
  - low_run reaching VGAP_MIN → VBLANK. No frame_done is issued.
- VBLANK: de rise → ACTIVE. Start of a line at row=0; clear line_err and lit_acc; assert frame_start.
- ACTIVE:
  - Each de=1 sample is a pixel at (col,row). col increments.
  - pix_valid=1 only if col<LCD_WIDTH and row<LCD_HIGHT.
  - lit_acc increments if rgb≠0 and the pixel is valid.
  - de fall → HBLANK. If col≠LCD_WIDTH, set line_err. Then row++ and col=0.
- HBLANK:
  - de rise → ACTIVE (next line). low_run cleared.
  - low_run reaching VGAP_MIN → VBLANK. Pulse frame_done, latch frame_err = (row≠LCD_HIGHT), latch lit_count=lit_acc.
- lit_count and frame_err hold until the next frame_done.
- line_err holds until the next frame_start.
- Lines longer than LCD_WIDTH: excess pixels are dropped (pix_valid=0). Lines beyond LCD_HIGHT: all pixels are dropped. Error flags report both conditions.
- Single-cycle de glitches are treated as real lines: they produce line_err and count toward row.

## Timing
- Reset values: all outputs 0, state=SYNC, all counters 0.
- Reset has priority over all events, including mid-line. After reset the block discards data until a full VGAP_MIN gap is seen.
- Pixel latency: 1 cycle. pix_* and frame_start reflect the sample taken on the previous edge.
- frame_done is asserted the cycle after the sample that brings low_run to VGAP_MIN. frame_err and lit_count are valid in that same cycle.
- A line-ending de fall and the line_err update become visible 1 cycle after the first de=0 sample.
- A de rise on the same sample where low_run would hit VGAP_MIN does not happen: low_run only counts de=0 samples, so the rise wins (line, not frame).
- Nominal input (800 clk/line, 525 lines): frame_done fires once per 420000 cycles, 1024 cycles after the last active pixel of row 479.

## Structure
- Shared package lcd_pkg holds:
  - LCD_WIDTH, LCD_HIGHT, H_BLANKING, V_BLANKING constants (shared with the transmitter).
  - The state enum {SYNC, VBLANK, ACTIVE, HBLANK}.
- Single module; no sub-module is warranted. Counters and the FSM live in one sequential block, with registered outputs.

## Test plan
- Nominal frames: drive 3 frames of 640×480 with 160-clk H-blank and 45-line V-blank, rgb=24'hFFFFFF on even columns.
  - First frame_done occurs after the first frame_start; no pixel is reported before that frame_start.
  - Each frame: lit_count=153600, frame_err=0, line_err=0.
  - pix_x/pix_y sweep 0..639/0..479.
- Short line: drive row 10 with 639 pixels.
  - line_err=1 from the end of row 10 until the next frame_start.
  - frame_err=0.
- Long line: drive row 5 with 650 pixels.
  - Pixels 640..649 have pix_valid=0.
  - line_err=1.
- Row count mismatch: frame with 481 lines → frame_err=1 and row-480 pixels are not valid. Frame with 479 lines → frame_err=1.
- Reset mid-line:
  - Assert rst at row 200, col 300 → outputs clear the next cycle.
  - Remainder of the frame ignored; no frame_done until a full gap is seen.
  - Next frame captured correctly.
- Gap threshold: a DE-low gap of VGAP_MIN-1 does not end the frame. A gap of exactly VGAP_MIN pulses frame_done exactly once.
